// File: rtl/ysyx_23060203_ifu_pkg.sv
// Shared definitions for the ysyx_23060203 instruction fetch unit:
// RV32 opcode constants, performance event ids and the fetch FSM state type.
package ysyx_23060203_ifu_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_e;

  typedef enum int {
    PERF_IFU_FETCH   = 0,
    PERF_IFU_WAIT    = 1,
    PERF_IFU_DISCARD = 2
  } perf_ifu_e;

endpackage

// File: rtl/ysyx_23060203_ifu_bpu.sv
// Static predictor: backward conditional branches are predicted taken,
// everything else (including JAL/JALR and forward branches) falls through.
module ysyx_23060203_ifu_bpu
  import ysyx_23060203_ifu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] npc_o
);

  logic [31:0] imm_b;
  logic        bwd_br;
  logic        unused_bits;

  assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  // Sign bit of the B-immediate is inst[31], so a set bit means a backward target.
  assign bwd_br = (inst_i[6:2] == OP_BRANCH[6:2]) && inst_i[31];
  // Fields the predictor does not need (funct3, rs1, rs2, length bits).
  assign unused_bits = ^{inst_i[24:12], inst_i[1:0]};
  assign npc_o  = bwd_br ? (pc_i + imm_b) : (pc_i + 32'd4);

endmodule

// File: rtl/ysyx_23060203_ifu.sv
module ysyx_23060203_ifu
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_dnpc,
  input  logic        jump_flush,
  input  logic [31:0] jump_dnpc,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        discard_q, discard_d;
  logic        arvalid_q, arvalid_d;

  logic        redirect;
  logic [31:0] redir_tgt;
  logic [31:0] pred_npc;

  assign redirect  = flush | jump_flush;
  assign redir_tgt = flush ? flush_dnpc : jump_dnpc;

  ysyx_23060203_ifu_bpu u_bpu (
    .pc_i   (pc_q),
    .inst_i (mem_rdata),
    .npc_o  (pred_npc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      redir_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      arvalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      redir_pc_q <= redir_pc_d;
      discard_q  <= discard_d;
      arvalid_q  <= arvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    redir_pc_d = redir_pc_q;
    discard_d  = discard_q;
    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          discard_d  = 1'b1;
          redir_pc_d = redir_tgt;
        end
        if (arvalid_q && mem_arready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          if (discard_q || redirect) begin
            pc_d      = redirect ? redir_tgt : redir_pc_q;
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            inst_d     = mem_rdata;
            redir_pc_d = pred_npc;
            state_d    = ST_HOLD;
          end
        end else if (redirect) begin
          discard_d  = 1'b1;
          redir_pc_d = redir_tgt;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt;
          state_d = ST_REQ;
        end else if (out_ready) begin
          pc_d    = redir_pc_q;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
    arvalid_d = (state_d == ST_REQ);
  end

  always_comb begin
    mem_rready = (state_q == ST_WAIT);
    out_valid  = (state_q == ST_HOLD) & ~flush & ~jump_flush;
  end

  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = pc_q;
  assign out_pc      = pc_q;
  assign out_inst    = inst_q;

`ifdef YSYX_23060203_IFU_PERF_EN
`ifndef SYNTHESIS
  logic [63:0] perf_fetch_q, perf_wait_q, perf_discard_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_q   <= 64'h0;
      perf_wait_q    <= 64'h0;
      perf_discard_q <= 64'h0;
    end else if (state_q == ST_WAIT) begin
      perf_wait_q <= perf_wait_q + 64'd1;
      if (mem_rvalid) begin
        if (discard_q || redirect) perf_discard_q <= perf_discard_q + 64'd1;
        else                       perf_fetch_q   <= perf_fetch_q + 64'd1;
      end
    end
  end
`endif
`endif

endmodule
